gold_scrambler: RTL and testbench

- Parametrised successor to the fixed-seed CCSDS/DVB-S2 Gold-code randomizer (CCSDS 131.2-B App. C).
- Generates R_n(i) in {0..3} from the 18-bit x/y LFSR pair.
- Runtime code number n is loaded by a seek FSM. The sequence restarts at every frame boundary.
- Rotates a streaming complex I/Q sample by R·90° behind a valid/ready handshake. Sits between the PL-frame mapper and the pulse shaper.

---
 rtl/gold_scrambler_if.sv | 8 +
 rtl/gold_scrambler.sv | 129 ++++++++++++
 tb/tb_gold_scrambler.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gold_scrambler_if.sv
// gold_scrambler_if: I/Q sample stream into and out of the Gold-code scrambler.
interface gold_scrambler_if #(parameter int DATA_W = 8);
    logic              i_valid, o_ready, o_valid, i_ready, o_sof;
    logic [DATA_W-1:0] i_i, i_q, o_i, o_q;
    logic [1:0]        o_r;
    modport master (output i_valid, i_i, i_q, i_ready, input o_ready, o_valid, o_i, o_q, o_r, o_sof);
    modport slave  (input i_valid, i_i, i_q, i_ready, output o_ready, o_valid, o_i, o_q, o_r, o_sof);
endinterface

// File: rtl/gold_scrambler.sv
// gold_scrambler: rotates I/Q samples by R*90deg from a seekable 18-bit Gold code, restarting every frame.
// Optional GOLD_SCRAMBLER_BYPASS_EN adds i_bypass to pass samples unrotated while the code keeps advancing.
module gold_scrambler #(
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 16200,
    parameter int SEED_N    = 0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [17:0] i_code_n,
    input  logic        i_code_load,
    output logic        o_busy,
`ifdef GOLD_SCRAMBLER_BYPASS_EN
    input  logic        i_bypass,
`endif
    gold_scrambler_if.slave s
);
    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
    localparam logic [17:0] X_BASE = 18'h00001;
    localparam logic [17:0] Y_BASE = 18'h3FFFF;
    localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MAX_V = ~MIN_V;

    typedef enum logic {SEEK, RUN} state_t;

    state_t      state, state_d;
    logic [17:0] x, x_d, y, y_d, seed_x, seed_d, n, n_d, seek_cnt, seek_d;
    logic [CW-1:0] sym_cnt, sym_d;
    logic [1:0]  r_cur, r_app;
    logic        xfer;
    logic [DATA_W-1:0] rot_i, rot_q;

    function automatic logic [17:0] x_step(input logic [17:0] v);
        return {v[7] ^ v[0], v[17:1]};
    endfunction

    function automatic logic [17:0] y_step(input logic [17:0] v);
        return {v[10] ^ v[7] ^ v[5] ^ v[0], v[17:1]};
    endfunction

    // Negation saturates so that the most negative sample cannot wrap to itself.
    function automatic logic [DATA_W-1:0] neg(input logic [DATA_W-1:0] v);
        return (v == MIN_V) ? MAX_V : -v;
    endfunction

    assign r_cur = {^{x[4], x[6], x[15], y[5], y[6], y[15:8]}, x[0] ^ y[0]};
`ifdef GOLD_SCRAMBLER_BYPASS_EN
    assign r_app = i_bypass ? 2'd0 : r_cur;
`else
    assign r_app = r_cur;
`endif

    assign rot_i = (r_app == 2'd0) ? s.i_i : (r_app == 2'd1) ? neg(s.i_q) : (r_app == 2'd2) ? neg(s.i_i) : s.i_q;
    assign rot_q = (r_app == 2'd0) ? s.i_q : (r_app == 2'd1) ? s.i_i : (r_app == 2'd2) ? neg(s.i_q) : neg(s.i_i);

    // A code load blocks acceptance in the same cycle so upstream never sees a dropped sample.
    assign o_busy    = (state == SEEK) && (seek_cnt != n);
    assign s.o_ready = (state == RUN) && !i_code_load && (!s.o_valid || s.i_ready);
    assign xfer      = s.i_valid && s.o_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= SEEK;
            x        <= X_BASE;
            y        <= Y_BASE;
            seed_x   <= X_BASE;
            n        <= 18'(SEED_N);
            seek_cnt <= '0;
            sym_cnt  <= '0;
        end else begin
            state    <= state_d;
            x        <= x_d;
            y        <= y_d;
            seed_x   <= seed_d;
            n        <= n_d;
            seek_cnt <= seek_d;
            sym_cnt  <= sym_d;
        end
    end

    always_comb begin
        state_d = state;
        x_d     = x;
        y_d     = y;
        seed_d  = seed_x;
        n_d     = n;
        seek_d  = seek_cnt;
        sym_d   = sym_cnt;
        if (i_code_load) begin
            n_d     = i_code_n;
            x_d     = X_BASE;
            seek_d  = '0;
            sym_d   = '0;
            state_d = SEEK;
        end else if (state == SEEK) begin
            if (seek_cnt == n) begin
                seed_d  = x;
                y_d     = Y_BASE;
                state_d = RUN;
            end else begin
                x_d    = x_step(x);
                seek_d = seek_cnt + 18'd1;
            end
        end else if (xfer) begin
            x_d   = (sym_cnt == LAST) ? seed_x : x_step(x);
            y_d   = (sym_cnt == LAST) ? Y_BASE : y_step(y);
            sym_d = (sym_cnt == LAST) ? '0 : sym_cnt + CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s.o_valid <= 1'b0;
            s.o_i     <= '0;
            s.o_q     <= '0;
            s.o_r     <= '0;
            s.o_sof   <= 1'b0;
        end else if (xfer) begin
            s.o_valid <= 1'b1;
            s.o_i     <= rot_i;
            s.o_q     <= rot_q;
            s.o_r     <= r_app;
            s.o_sof   <= (sym_cnt == '0);
        end else if (s.i_ready) begin
            s.o_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_gold_scrambler.sv
// tb_gold_scrambler: table vectors, directed corner sequences and a randomized stream
// checked against a sequence-array reference model of the Gold scrambler.
module tb_gold_scrambler;
    localparam int DW = 8;
    localparam int FL = 4;
    localparam int P = 262143;
    localparam int MAXV = 2 ** (DW - 1) - 1;
    localparam int MINV = -(2 ** (DW - 1));
    localparam logic [17:0] XM = 18'h08050;
    localparam logic [17:0] YM = 18'h0FF60;

    typedef struct {int i, q, r, sof;} out_t;
    typedef struct {int in_i, in_q, ei, eq, er, esof;} vec_t;

    logic clk = 1'b0, rst = 1'b1, code_load = 1'b0, busy;
    logic [17:0] code_n = '0;
    int errors = 0, checks = 0;
    int m_n = 0, m_k = 0;
    logic [17:0] xseq[P];
    logic [17:0] yseq[FL];
    out_t sbq[$];

    always #5 clk = ~clk;

    gold_scrambler_if #(.DATA_W(DW)) bus();

    gold_scrambler #(.DATA_W(DW), .FRAME_LEN(FL), .SEED_N(0)) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_code_n(code_n),
        .i_code_load(code_load),
        .o_busy(busy),
`ifdef GOLD_SCRAMBLER_BYPASS_EN
        .i_bypass(1'b0),
`endif
        .s(bus)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int model_r(input int n, input int k);
        logic [17:0] x, y;
        bit hi, lo;
        x = xseq[(n + k) % P];
        y = yseq[k];
        hi = (^(x & XM)) ^ (^(y & YM));
        lo = x[0] ^ y[0];
        return int'({hi, lo});
    endfunction

    function automatic int sat(input int v);
        return (v > MAXV) ? MAXV : (v < MINV) ? MINV : v;
    endfunction

    // Multiply (I + jQ) by j^r in plain integers, then clamp to the sample range.
    function automatic out_t expect_out(input int i, input int q, input int r, input int k);
        out_t e;
        int a = i, b = q, t;
        for (int c = 0; c < r; c++) begin
            t = a;
            a = -b;
            b = t;
        end
        e.i = sat(a);
        e.q = sat(b);
        e.r = r;
        e.sof = (k == 0);
        return e;
    endfunction

    task automatic tick();
        bit fin, fout;
        out_t e;
        #4;
        fout = bus.o_valid && bus.i_ready;
        fin  = bus.i_valid && bus.o_ready && !code_load;
        if (bus.o_valid && !bus.i_ready) begin
            chk("ready_while_stalled", int'(bus.o_ready), 0);
            if (sbq.size() > 0) begin
                chk("hold_i", int'($signed(bus.o_i)), sbq[0].i);
                chk("hold_q", int'($signed(bus.o_q)), sbq[0].q);
                chk("hold_r", int'(bus.o_r), sbq[0].r);
            end
        end
        if (busy) chk("ready_while_busy", int'(bus.o_ready), 0);
        if (fout) begin
            if (sbq.size() == 0) chk("sb_unexpected_out", sbq.size(), 1);
            else begin
                e = sbq.pop_front();
                chk("sb_i", int'($signed(bus.o_i)), e.i);
                chk("sb_q", int'($signed(bus.o_q)), e.q);
                chk("sb_r", int'(bus.o_r), e.r);
                chk("sb_sof", int'(bus.o_sof), e.sof);
            end
        end
        if (code_load) begin
            m_n = int'(code_n);
            m_k = 0;
        end
        if (fin) begin
            sbq.push_back(expect_out(int'($signed(bus.i_i)), int'($signed(bus.i_q)), model_r(m_n, m_k), m_k));
            m_k = (m_k + 1) % FL;
        end
        @(negedge clk);
    endtask

    task automatic load_code(input int n, output int cyc);
        bus.i_valid = 1'b0;
        code_n = 18'(n);
        code_load = 1'b1;
        tick();
        code_load = 1'b0;
        cyc = 0;
        while (busy && cyc < n + 20) begin
            cyc++;
            tick();
        end
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[3];
        int cyc, rs[9], sofs[9], sat_c;
        bit h1, h2;
        xseq[0] = 18'h00001;
        for (int i = 1; i < P; i++) xseq[i] = {xseq[i-1][7] ^ xseq[i-1][0], xseq[i-1][17:1]};
        yseq[0] = 18'h3FFFF;
        for (int i = 1; i < FL; i++)
            yseq[i] = {yseq[i-1][10] ^ yseq[i-1][7] ^ yseq[i-1][5] ^ yseq[i-1][0], yseq[i-1][17:1]};
        tbl[0] = '{10, 3, 10, 3, 0, 1};
        tbl[1] = '{10, 3, -3, 10, 1, 0};
        tbl[2] = '{10, 3, -3, 10, 1, 0};
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        bus.i_i = '0;
        bus.i_q = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(bus.o_ready), 0);
        chk("rst_valid", int'(bus.o_valid), 0);
        chk("rst_oi", int'(bus.o_i), 0);
        chk("rst_oq", int'(bus.o_q), 0);
        chk("rst_r", int'(bus.o_r), 0);
        chk("rst_sof", int'(bus.o_sof), 0);
        tick();
        chk("seed0_busy", int'(busy), 0);
        for (int v = 0; v < 3; v++) begin
            bus.i_valid = 1'b1;
            bus.i_i = DW'(tbl[v].in_i);
            bus.i_q = DW'(tbl[v].in_q);
            tick();
            chk("tbl_valid", int'(bus.o_valid), 1);
            chk("tbl_i", int'($signed(bus.o_i)), tbl[v].ei);
            chk("tbl_q", int'($signed(bus.o_q)), tbl[v].eq);
            chk("tbl_r", int'(bus.o_r), tbl[v].er);
            chk("tbl_sof", int'(bus.o_sof), tbl[v].esof);
        end
        // Code 5 seek length, then nine transfers spanning two frame wraps.
        load_code(5, cyc);
        chk("busy_cycles_5", cyc, 5);
        for (int j = 0; j < 9; j++) begin
            bus.i_valid = 1'b1;
            bus.i_i = DW'($urandom_range(0, 255));
            bus.i_q = DW'($urandom_range(0, 255));
            tick();
            rs[j] = int'(bus.o_r);
            sofs[j] = int'(bus.o_sof);
        end
        chk("wrap_r4", rs[4], model_r(5, 0));
        chk("wrap_r8", rs[8], model_r(5, 0));
        for (int j = 0; j < 9; j++) chk("wrap_sof", sofs[j], (j % FL == 0) ? 1 : 0);
        // Saturation on most-negative input, on a code whose frame holds both R=1 and R=2.
        sat_c = -1;
        for (int c = 0; c < 500 && sat_c < 0; c++) begin
            h1 = 0;
            h2 = 0;
            for (int k = 0; k < FL; k++) begin
                if (model_r(c, k) == 1) h1 = 1;
                if (model_r(c, k) == 2) h2 = 1;
            end
            if (h1 && h2) sat_c = c;
        end
        chk("sat_code_found", int'(sat_c >= 0), 1);
        if (sat_c < 0) sat_c = 0;
        load_code(sat_c, cyc);
        chk("busy_cycles_sat", cyc, sat_c);
        for (int k = 0; k < FL; k++) begin
            bus.i_valid = 1'b1;
            bus.i_i = DW'(MINV);
            bus.i_q = DW'(MINV);
            tick();
            if (model_r(sat_c, k) == 2) begin
                chk("sat_r2_i", int'($signed(bus.o_i)), 127);
                chk("sat_r2_q", int'($signed(bus.o_q)), 127);
            end
            if (model_r(sat_c, k) == 1) begin
                chk("sat_r1_i", int'($signed(bus.o_i)), 127);
                chk("sat_r1_q", int'($signed(bus.o_q)), -128);
            end
        end
        // Three-cycle downstream stall with input still offered, then release.
        bus.i_i = DW'(17);
        bus.i_q = DW'(-40);
        tick();
        bus.i_ready = 1'b0;
        repeat (3) tick();
        chk("stall_valid", int'(bus.o_valid), 1);
        bus.i_ready = 1'b1;
        repeat (3) tick();
        // Code load while an output is pending mid-frame.
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        load_code(11, cyc);
        chk("busy_cycles_11", cyc, 11);
        chk("pending_valid", int'(bus.o_valid), 1);
        bus.i_ready = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_i = DW'(5);
        bus.i_q = DW'(9);
        tick();
        chk("newcode_sof", int'(bus.o_sof), 1);
        chk("newcode_r", int'(bus.o_r), model_r(11, 0));
        tick();
        // Load coincident with valid input: the load wins, nothing is accepted.
        code_n = 18'd3;
        code_load = 1'b1;
        tick();
        code_load = 1'b0;
        bus.i_valid = 1'b0;
        chk("load_wins_valid", int'(bus.o_valid), 0);
        cyc = 0;
        while (busy && cyc < 30) begin
            cyc++;
            tick();
        end
        chk("busy_cycles_3", cyc, 3);
        // Randomized traffic over several random codes.
        for (int rnd = 0; rnd < 6; rnd++) begin
            int n = $urandom_range(0, 60);
            load_code(n, cyc);
            chk("busy_cycles_rand", cyc, n);
            for (int c = 0; c < 80; c++) begin
                bus.i_valid = ($urandom_range(0, 9) < 7);
                bus.i_ready = ($urandom_range(0, 9) < 7);
                bus.i_i = DW'($urandom_range(0, 255));
                bus.i_q = DW'($urandom_range(0, 255));
                tick();
            end
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        repeat (3) tick();
        chk("drain_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
